trng_dbg_csr: RTL and testbench

Parametrised debug and control register block for the Cryptech TRNG, serving up to `NUM_CH` CSPRNG channels. It sits on the TRNG-internal 8-bit address / 32-bit data register bus. It drives the CSPRNG debug mode, round count and per-channel reseed pulses, and captures per-channel CSPRNG errors in sticky status bits and saturating counters. Debug mode is guarded by a key-unlock state machine; any illegal attempt to enable it raises `security_error`.

---
 rtl/trng_dbg_csr.sv | 248 ++++++++++++++++++++++++
 tb/tb_trng_dbg_csr.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_dbg_csr.sv
// Debug/control register block for the Cryptech TRNG CSPRNG channels: key-guarded debug mode,
// round count, reseed pulses and sticky error capture. Define TRNG_DBG_ERRCNT_EN for per-channel error counters.
module trng_dbg_csr #(
    parameter int unsigned NUM_CH         = 2,
    parameter logic [4:0]  DEFAULT_ROUNDS = 5'd24,
    parameter logic [4:0]  MIN_ROUNDS     = 5'd8,
    parameter logic [31:0] UNLOCK_KEY     = 32'h6465_6267,
    parameter int unsigned UNLOCK_WINDOW  = 16,
    parameter int unsigned ERR_CNT_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              we,
    input  logic [7:0]        address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              error,
    output logic              csprng_debug_mode,
    output logic [4:0]        csprng_num_rounds,
    output logic [NUM_CH-1:0] csprng_reseed,
    input  logic [NUM_CH-1:0] csprng_error,
    output logic              security_error
);

    localparam logic [7:0] ADDR_NAME0     = 8'h00;
    localparam logic [7:0] ADDR_NAME1     = 8'h01;
    localparam logic [7:0] ADDR_VERSION   = 8'h02;
    localparam logic [7:0] ADDR_CTRL      = 8'h08;
    localparam logic [7:0] ADDR_RESEED    = 8'h09;
    localparam logic [7:0] ADDR_STATUS    = 8'h0a;
    localparam logic [7:0] ADDR_UNLOCK    = 8'h0b;
    localparam logic [7:0] ADDR_LOCKSTATE = 8'h0c;
    localparam logic [7:0] ADDR_ERRCNT    = 8'h10;

    localparam logic [31:0] CORE_NAME0   = 32'h7472_6e67;
    localparam logic [31:0] CORE_NAME1   = 32'h2d64_6267;
    localparam logic [31:0] CORE_VERSION = 32'h312e_3030;

    localparam int unsigned      WIN_W    = (UNLOCK_WINDOW > 1) ? $clog2(UNLOCK_WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(UNLOCK_WINDOW - 1);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        ARMED    = 2'd1,
        UNLOCKED = 2'd2
    } lock_state_e;

    lock_state_e       state_q, state_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic              debug_q, debug_d;
    logic [4:0]        rounds_q, rounds_d;
    logic [NUM_CH-1:0] reseed_q, reseed_d;
    logic              sec_q, sec_d;
    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic [NUM_CH-1:0] err_s_q, err_s_d;
    logic [NUM_CH-1:0] err_q, err_d;

    logic              wr, wr_ctrl, wr_reseed, wr_status, wr_unlock;
    logic              wr_dbg, rounds_ok, key_ok;
    logic [4:0]        wr_rounds;
    logic [NUM_CH-1:0] rise;
    logic              cnt_hit;
    logic [31:0]       cnt_rdata;
    logic              unused_wdata;

    assign unused_wdata = ^write_data;

    // Access decode shared by the state, control and read paths.
    always_comb begin
        wr        = cs & we;
        wr_ctrl   = wr && (address == ADDR_CTRL);
        wr_reseed = wr && (address == ADDR_RESEED);
        wr_status = wr && (address == ADDR_STATUS);
        wr_unlock = wr && (address == ADDR_UNLOCK);
        wr_dbg    = write_data[0];
        wr_rounds = write_data[12:8];
        rounds_ok = (wr_rounds >= MIN_ROUNDS);
        key_ok    = (write_data == UNLOCK_KEY);
        rise      = err_s_q & ~err_q;
    end

    // Unlock FSM; a debug enable in the final ARMED cycle beats window expiry.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        case (state_q)
            LOCKED: begin
                if (wr_unlock && key_ok) begin
                    state_d = ARMED;
                    win_d   = WIN_LOAD;
                end
            end
            ARMED: begin
                if (wr_ctrl && rounds_ok && wr_dbg) begin
                    state_d = UNLOCKED;
                end else if (win_q == '0) begin
                    state_d = LOCKED;
                end else begin
                    win_d = win_q - WIN_W'(1);
                end
            end
            UNLOCKED: begin
                if (wr_ctrl && rounds_ok && !wr_dbg) begin
                    state_d = LOCKED;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    // Control fields, reseed pulses, security flag and sticky error bits.
    always_comb begin
        debug_d  = (state_d == UNLOCKED);
        rounds_d = rounds_q;
        reseed_d = '0;
        sec_d    = sec_q;
        sticky_d = sticky_q;
        err_s_d  = csprng_error;
        err_d    = err_s_q;
        if (wr_ctrl && rounds_ok) begin
            rounds_d = wr_rounds;
        end
        if (wr_reseed) begin
            reseed_d = write_data[NUM_CH-1:0];
        end
        if (wr_status) begin
            sticky_d = sticky_q & ~write_data[NUM_CH-1:0];
            if (write_data[16]) begin
                sec_d = 1'b0;
            end
        end
        if ((state_q == LOCKED) && ((wr_ctrl && wr_dbg) || (wr_unlock && !key_ok))) begin
            sec_d = 1'b1;
        end
        sticky_d = sticky_d | rise;
    end

`ifdef TRNG_DBG_ERRCNT_EN
    logic [ERR_CNT_WIDTH-1:0] cnt_q [NUM_CH];
    logic [ERR_CNT_WIDTH-1:0] cnt_d [NUM_CH];

    // Clear is applied before the increment so a coincident error edge leaves the count at 1.
    always_comb begin
        cnt_hit   = 1'b0;
        cnt_rdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (address == (ADDR_ERRCNT + 8'(i))) begin
                cnt_hit   = 1'b1;
                cnt_rdata = 32'(cnt_q[i]);
                if (wr) begin
                    cnt_d[i] = '0;
                end
            end
            if (rise[i] && (cnt_d[i] != '1)) begin
                cnt_d[i] = cnt_d[i] + ERR_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unsigned unused_cnt_w = ERR_CNT_WIDTH;

    always_comb begin
        cnt_hit   = 1'b0;
        cnt_rdata = '0;
    end
`endif

    // Combinational read mux and access error.
    always_comb begin
        read_data = '0;
        error     = 1'b0;
        case (address)
            ADDR_NAME0: begin
                read_data = CORE_NAME0;
                error     = we;
            end
            ADDR_NAME1: begin
                read_data = CORE_NAME1;
                error     = we;
            end
            ADDR_VERSION: begin
                read_data = CORE_VERSION;
                error     = we;
            end
            ADDR_CTRL: begin
                read_data = {19'b0, rounds_q, 7'b0, debug_q};
                error     = we && (!rounds_ok || (wr_dbg && (state_q == LOCKED)));
            end
            ADDR_RESEED: read_data = '0;
            ADDR_STATUS: read_data = 32'(sticky_q) | {15'b0, sec_q, 16'b0};
            ADDR_UNLOCK: error = we && !key_ok && (state_q == LOCKED);
            ADDR_LOCKSTATE: begin
                read_data = {30'b0, state_q};
                error     = we;
            end
            default: begin
                read_data = cnt_rdata;
                error     = !cnt_hit;
            end
        endcase
        if (!cs) begin
            read_data = '0;
            error     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOCKED;
            win_q    <= '0;
            debug_q  <= 1'b0;
            rounds_q <= DEFAULT_ROUNDS;
            reseed_q <= '0;
            sec_q    <= 1'b0;
            sticky_q <= '0;
            err_s_q  <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            debug_q  <= debug_d;
            rounds_q <= rounds_d;
            reseed_q <= reseed_d;
            sec_q    <= sec_d;
            sticky_q <= sticky_d;
            err_s_q  <= err_s_d;
            err_q    <= err_d;
        end
    end

    assign csprng_debug_mode = debug_q;
    assign csprng_num_rounds = rounds_q;
    assign csprng_reseed     = reseed_q;
    assign security_error    = sec_q;

endmodule

// File: tb/tb_trng_dbg_csr.sv
// Scoreboard bench for trng_dbg_csr: driver pushes model expectations per cycle, monitor compares at negedge.
module tb_trng_dbg_csr;

    localparam int unsigned NUM_CH  = 2;
    localparam logic [31:0] KEY     = 32'h6465_6267;
    localparam int          WINDOW  = 16;
    localparam int          MIN_R   = 8;
    localparam int          CNT_MAX = 255;
`ifdef TRNG_DBG_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cs;
    logic              we;
    logic [7:0]        address;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              error;
    logic              csprng_debug_mode;
    logic [4:0]        csprng_num_rounds;
    logic [NUM_CH-1:0] csprng_reseed;
    logic [NUM_CH-1:0] csprng_error;
    logic              security_error;

    always #5 clk = ~clk;

    trng_dbg_csr #(
        .NUM_CH        (NUM_CH),
        .DEFAULT_ROUNDS(5'd24),
        .MIN_ROUNDS    (5'd8),
        .UNLOCK_KEY    (KEY),
        .UNLOCK_WINDOW (WINDOW),
        .ERR_CNT_WIDTH (8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cs               (cs),
        .we               (we),
        .address          (address),
        .write_data       (write_data),
        .read_data        (read_data),
        .error            (error),
        .csprng_debug_mode(csprng_debug_mode),
        .csprng_num_rounds(csprng_num_rounds),
        .csprng_reseed    (csprng_reseed),
        .csprng_error     (csprng_error),
        .security_error   (security_error)
    );

    typedef struct {
        logic [7:0]        addr;
        bit                rd;
        logic [31:0]       rdata;
        logic              err;
        logic              dbg;
        logic [4:0]        rounds;
        logic [NUM_CH-1:0] reseed;
        logic              sec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_mis = 0;

    // Reference model: lock state as 0/1/2, ARMED lifetime tracked by the cycle number of the key write.
    int m_state, m_armed_at, m_rounds, m_reseed, m_cyc;
    bit m_dbg, m_sec;
    bit m_sticky[NUM_CH];
    int m_cnt[NUM_CH];
    bit m_h1[NUM_CH];
    bit m_h2[NUM_CH];

    function automatic void model_reset();
        m_state  = 0;
        m_rounds = 24;
        m_reseed = 0;
        m_dbg    = 1'b0;
        m_sec    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_sticky[i] = 1'b0;
            m_cnt[i]    = 0;
            m_h1[i]     = 1'b0;
            m_h2[i]     = 1'b0;
        end
    endfunction

    function automatic logic [31:0] status_word();
        logic [31:0] s = 32'(m_sec) << 16;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_sticky[i]) s = s | (32'd1 << i);
        end
        return s;
    endfunction

    function automatic void model_resp(input bit w, input int a, input logic [31:0] d,
                                       output logic [31:0] rd, output logic e);
        rd = '0;
        e  = 1'b0;
        if (a == 0) begin rd = 32'h7472_6e67; e = w; end
        else if (a == 1) begin rd = 32'h2d64_6267; e = w; end
        else if (a == 2) begin rd = 32'h312e_3030; e = w; end
        else if (a == 8) begin
            rd = 32'(m_rounds * 256 + int'(m_dbg));
            e  = w && ((int'(d[12:8]) < MIN_R) || (d[0] && m_state == 0));
        end
        else if (a == 9) e = 1'b0;
        else if (a == 10) rd = status_word();
        else if (a == 11) e = w && (m_state == 0) && (d != KEY);
        else if (a == 12) begin rd = 32'(m_state); e = w; end
        else if (a >= 16 && a < 16 + NUM_CH) begin
            if (CNT_EN) rd = 32'(m_cnt[a - 16]);
            else e = 1'b1;
        end
        else e = 1'b1;
    endfunction

    function automatic void model_edge(input bit w, input int a, input logic [31:0] d,
                                       input logic [NUM_CH-1:0] ein);
        int old_state = m_state;
        bit accepted  = 1'b0;
        int r         = int'(d[12:8]);
        m_reseed = 0;
        if (w) begin
            if (a == 8) begin
                if (d[0] && old_state == 0) m_sec = 1'b1;
                if (r >= MIN_R) begin
                    m_rounds = r;
                    if (d[0] && old_state == 1) begin m_state = 2; accepted = 1'b1; end
                    if (!d[0] && old_state == 2) m_state = 0;
                end
            end else if (a == 9) begin
                m_reseed = int'(d[NUM_CH-1:0]);
            end else if (a == 10) begin
                for (int i = 0; i < NUM_CH; i++) if (d[i]) m_sticky[i] = 1'b0;
                if (d[16]) m_sec = 1'b0;
            end else if (a == 11) begin
                if (old_state == 0) begin
                    if (d == KEY) begin m_state = 1; m_armed_at = m_cyc; end
                    else m_sec = 1'b1;
                end
            end else if (a >= 16 && a < 16 + NUM_CH) begin
                m_cnt[a - 16] = 0;
            end
        end
        if (old_state == 1 && !accepted && (m_cyc - m_armed_at) >= WINDOW) m_state = 0;
        m_dbg = (m_state == 2);
        // An input edge becomes visible two edges after it is presented.
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_h1[i] && !m_h2[i]) begin
                m_sticky[i] = 1'b1;
                if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
            end
            m_h2[i] = m_h1[i];
            m_h1[i] = ein[i];
        end
        m_cyc++;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.rd) check($sformatf("read_data@%02h", mon_e.addr), read_data, mon_e.rdata);
            check($sformatf("error@%02h", mon_e.addr), 32'(error), 32'(mon_e.err));
            check("debug_mode", 32'(csprng_debug_mode), 32'(mon_e.dbg));
            check("num_rounds", 32'(csprng_num_rounds), 32'(mon_e.rounds));
            check("reseed", 32'(csprng_reseed), 32'(mon_e.reseed));
            check("security_error", 32'(security_error), 32'(mon_e.sec));
        end
    end

    task automatic push_expect(input bit c, input bit w, input logic [7:0] a, input logic [31:0] d);
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        model_resp(w, int'(a), d, rd, er);
        e.addr   = a;
        e.rd     = c && !w;
        e.rdata  = rd;
        e.err    = c ? er : 1'b0;
        e.dbg    = m_dbg;
        e.rounds = 5'(m_rounds);
        e.reseed = NUM_CH'(m_reseed);
        e.sec    = m_sec;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit c, input bit w, input logic [7:0] a, input logic [31:0] d);
        cs         = c;
        we         = w;
        address    = a;
        write_data = d;
        push_expect(c, w, a, d);
        model_edge(c && w, int'(a), d, csprng_error);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        cycle(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    logic [7:0]  r_a;
    logic [31:0] r_d;
    bit          r_c, r_w;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_cmp);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        reset_n = 1'b0; cs = 1'b0; we = 1'b0; address = '0; write_data = '0; csprng_error = '0;
        m_cyc = 0; m_armed_at = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // identification and reset values
        rd(8'h00); rd(8'h01); rd(8'h02); rd(8'h08); rd(8'h0c); rd(8'h0a);
        // illegal debug enable while locked, then clear the flag
        wr(8'h08, 32'h0000_0001); rd(8'h0a); wr(8'h0a, 32'h0001_0000); rd(8'h0a);
        // unlock inside the window, then lock again
        wr(8'h0b, KEY); idle(15); wr(8'h08, 32'h0000_1001); rd(8'h0c); rd(8'h08);
        wr(8'h08, 32'h0000_1000); rd(8'h0c);
        // window expired: attempt is rejected
        wr(8'h0b, KEY); idle(16); wr(8'h08, 32'h0000_1001); rd(8'h0c); rd(8'h0a);
        wr(8'h0b, 32'h1234_5678); rd(8'h0c);
        wr(8'h0a, 32'h0001_0000);
        // reseed pulse and rejected round count
        wr(8'h09, 32'h3); idle(2); wr(8'h09, 32'h1); wr(8'h09, 32'h2); idle(1);
        wr(8'h08, 32'h0000_0700); rd(8'h08);
        // unmapped and read-only writes
        wr(8'h00, 32'h1); wr(8'h0c, 32'h2); rd(8'h12); rd(8'h30); rd(8'h09);

        // error counter saturation
        for (int k = 0; k < 300; k++) begin
            csprng_error = 2'b10; idle(1);
            csprng_error = 2'b00; idle(1);
        end
        idle(2); rd(8'h0a); rd(8'h11); rd(8'h10);
        // clear coincident with an error edge
        csprng_error = 2'b10; idle(1); wr(8'h11, 32'h0); csprng_error = 2'b00; rd(8'h11);
        csprng_error = 2'b10; idle(1); wr(8'h0a, 32'h2); csprng_error = 2'b00; rd(8'h0a);
        wr(8'h0a, 32'h3); rd(8'h0a);

        // randomized traffic
        for (int k = 0; k < 700; k++) begin
            case ($urandom_range(0, 15))
                0: r_a = 8'h00;  1: r_a = 8'h01;  2: r_a = 8'h02;
                3, 4, 5: r_a = 8'h08;
                6: r_a = 8'h09;  7, 8: r_a = 8'h0a;
                9, 10: r_a = 8'h0b; 11: r_a = 8'h0c;
                12: r_a = 8'h10; 13: r_a = 8'h11; 14: r_a = 8'h12;
                default: r_a = 8'h30;
            endcase
            r_d = $urandom;
            if (r_a == 8'h08) begin
                r_d = 32'h0;
                r_d[12:8] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(8, 31));
                r_d[0] = 1'($urandom_range(0, 1));
            end
            if (r_a == 8'h0b && $urandom_range(0, 2) != 0) r_d = KEY;
            if (r_a == 8'h09) r_d = 32'($urandom_range(0, 3));
            r_c = ($urandom_range(0, 3) != 0);
            r_w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) csprng_error = NUM_CH'($urandom);
            cycle(r_c, r_w, r_a, r_d);
        end
        csprng_error = '0;
        idle(3);

        // asynchronous reset in the middle of a reseed pulse
        wr(8'h08, 32'h0000_0a01);
        wr(8'h09, 32'h3);
        cs = 1'b0; we = 1'b0;
        push_expect(1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset debug_mode", 32'(csprng_debug_mode), 32'd0);
        check("reset num_rounds", 32'(csprng_num_rounds), 32'd24);
        check("reset reseed", 32'(csprng_reseed), 32'd0);
        check("reset security_error", 32'(security_error), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        rd(8'h08); rd(8'h0a); rd(8'h0c); rd(8'h10);
        idle(1);

        cs = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
